// File: rtl/c17_pipe_array.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | c17_pipe_array : CHANNELS x ISCAS-85 c17 behind a STAGES-deep valid/ready |
// |                  pipeline; C17_BIST_EN adds an exhaustive self-test.      |
// | Revision       : 1.0                                                      |
// +---------------------------------------------------------------------------+
module c17_pipe_array #(
   parameter int CHANNELS = 4,
   parameter int STAGES   = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [5*CHANNELS-1:0] in_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [2*CHANNELS-1:0] out_data
`ifdef C17_BIST_EN
   ,
   input  logic                  bist_start,
   output logic                  bist_busy,
   output logic                  bist_done,
   output logic                  bist_pass
`endif
);

   localparam int RANK_R2 = (STAGES >= 2) ? STAGES - 2 : 0;
   localparam int RANK_R3 = (STAGES >= 1) ? STAGES - 1 : 0;

   generate
      if (STAGES < 1 || STAGES > 3) begin : g_bad_stages
         $error("c17_pipe_array: STAGES must be in 1..3");
      end
      if (CHANNELS < 1 || CHANNELS > 16) begin : g_bad_channels
         $error("c17_pipe_array: CHANNELS must be in 1..16");
      end
   endgenerate

   logic                  w_src_valid;
   logic [5*CHANNELS-1:0] w_src_data;
   logic                  w_sink_ready;
   logic                  w_flush;
   logic                  w_run;
   logic                  w_start;

   logic [STAGES-1:0]     r_v;
   logic [STAGES-1:0]     w_adv;
   logic [4*CHANNELS-1:0] r_r1;
   logic [3*CHANNELS-1:0] r_r2;
   logic [2*CHANNELS-1:0] r_r3;
   logic [4*CHANNELS-1:0] w_s1;
   logic [4*CHANNELS-1:0] w_s1_src;
   logic [3*CHANNELS-1:0] w_s2;
   logic [3*CHANNELS-1:0] w_s2_src;
   logic [2*CHANNELS-1:0] w_out;

   // Cut points collapse to wires for the ranks that do not exist at this depth.
   assign w_s1_src = (STAGES == 3) ? r_r1 : w_s1;
   assign w_s2_src = (STAGES >= 2) ? r_r2 : w_s2;

   generate
      for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
         logic w_n1, w_n2, w_n3, w_n6, w_n7;
         logic w_a10, w_a11, w_a2, w_a7;
         logic w_b10, w_b16, w_b19;
         assign {w_n7, w_n6, w_n3, w_n2, w_n1} = w_src_data[5*c +: 5];
         assign w_s1[4*c +: 4] = {~(w_n1 & w_n3), ~(w_n3 & w_n6), w_n2, w_n7};
         assign {w_a10, w_a11, w_a2, w_a7} = w_s1_src[4*c +: 4];
         assign w_s2[3*c +: 3] = {w_a10, ~(w_a2 & w_a11), ~(w_a11 & w_a7)};
         assign {w_b10, w_b16, w_b19} = w_s2_src[3*c +: 3];
         assign w_out[2*c +: 2] = {~(w_b16 & w_b19), ~(w_b10 & w_b16)};
      end
   endgenerate

   always_comb begin
      w_adv = '0;
      w_adv[STAGES-1] = w_sink_ready | ~r_v[STAGES-1];
      for (int k = STAGES - 2; k >= 0; k--) begin
         w_adv[k] = ~r_v[k] | w_adv[k+1];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_v <= '0;
      end else if (w_flush) begin
         r_v <= '0;
      end else begin
         if (w_adv[0]) r_v[0] <= w_src_valid;
         for (int k = 1; k < STAGES; k++) begin
            if (w_adv[k]) r_v[k] <= r_v[k-1];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_r1 <= '0;
         r_r2 <= '0;
         r_r3 <= '0;
      end else begin
         if (STAGES == 3 && w_adv[0])       r_r1 <= w_s1;
         if (STAGES >= 2 && w_adv[RANK_R2]) r_r2 <= w_s2;
         if (w_adv[RANK_R3])                r_r3 <= w_out;
      end
   end

   assign out_data = r_r3;

`ifdef C17_BIST_EN
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } bist_state_t;

   localparam logic [5:0] C_LAST = 6'(32 + STAGES - 1);

   bist_state_t           r_state;
   logic [5:0]            r_cyc;
   logic [4:0]            w_gidx;
   logic [2*CHANNELS-1:0] w_gold;

   function automatic logic [1:0] f_c17(input logic [4:0] v);
      logic n10, n11, n16, n19;
      n10 = ~(v[0] & v[2]);
      n11 = ~(v[2] & v[3]);
      n16 = ~(v[1] & n11);
      n19 = ~(n11 & v[4]);
      return {~(n16 & n19), ~(n10 & n16)};
   endfunction

   assign w_run        = (r_state == S_RUN);
   assign w_start      = bist_start & ~w_run;
   assign w_flush      = w_start | (w_run & (r_cyc == C_LAST));
   assign w_src_valid  = w_run ? (r_cyc < 6'd32) : in_valid;
   assign w_sink_ready = w_run | out_ready;
   assign w_gidx       = r_cyc[4:0] - 5'(STAGES);

   generate
      for (genvar c = 0; c < CHANNELS; c++) begin : g_bist_ch
         assign w_src_data[5*c +: 5] = w_run ? (r_cyc[4:0] + 5'(c)) : in_data[5*c +: 5];
         assign w_gold[2*c +: 2]     = f_c17(w_gidx + 5'(c));
      end
   endgenerate

   // A start request flushes the pipe that same edge, so nothing is accepted then.
   assign in_ready  = w_adv[0] & ~w_run & ~bist_start;
   assign out_valid = r_v[STAGES-1] & ~w_run;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_cyc     <= '0;
         bist_busy <= 1'b0;
         bist_done <= 1'b0;
         bist_pass <= 1'b0;
      end else begin
         case (r_state)
            S_RUN: begin
               r_cyc <= r_cyc + 6'd1;
               if (r_v[STAGES-1] && (r_r3 != w_gold)) bist_pass <= 1'b0;
               if (r_cyc == C_LAST) begin
                  r_state   <= S_DONE;
                  bist_busy <= 1'b0;
                  bist_done <= 1'b1;
               end
            end
            default: begin
               if (bist_start) begin
                  r_state   <= S_RUN;
                  r_cyc     <= '0;
                  bist_busy <= 1'b1;
                  bist_done <= 1'b0;
                  bist_pass <= 1'b1;
               end
            end
         endcase
      end
   end
`else
   assign w_run        = 1'b0;
   assign w_start      = 1'b0;
   assign w_flush      = 1'b0;
   assign w_src_valid  = in_valid;
   assign w_src_data   = in_data;
   assign w_sink_ready = out_ready;
   assign in_ready     = w_adv[0];
   assign out_valid    = r_v[STAGES-1];
`endif

endmodule
`default_nettype wire

// File: tb/tb_c17_pipe_array.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | tb_c17_pipe_array : randomized scoreboard bench for c17_pipe_array.       |
// | Revision          : 1.0                                                   |
// +---------------------------------------------------------------------------+
module tb_c17_pipe_array;
   localparam int CH = 4;
   localparam int S  = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic            rst, in_valid, out_ready;
   logic [5*CH-1:0] in_data;
   logic            in_ready, out_valid;
   logic [2*CH-1:0] out_data;
   logic            a1_in_ready, a1_out_valid, a2_in_ready, a2_out_valid;
   logic [2*CH-1:0] a1_out_data, a2_out_data;
`ifdef C17_BIST_EN
   logic bist_start;
   logic bist_busy, bist_done, bist_pass;
   logic a1_busy, a1_done, a1_pass, a2_busy, a2_done, a2_pass;
`endif

   c17_pipe_array #(.CHANNELS(CH), .STAGES(S)) u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
`ifdef C17_BIST_EN
      , .bist_start(bist_start), .bist_busy(bist_busy), .bist_done(bist_done), .bist_pass(bist_pass)
`endif
   );

   c17_pipe_array #(.CHANNELS(CH), .STAGES(1)) u_dut_s1 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a1_in_ready), .in_data(in_data),
      .out_valid(a1_out_valid), .out_ready(out_ready), .out_data(a1_out_data)
`ifdef C17_BIST_EN
      , .bist_start(bist_start), .bist_busy(a1_busy), .bist_done(a1_done), .bist_pass(a1_pass)
`endif
   );

   c17_pipe_array #(.CHANNELS(CH), .STAGES(2)) u_dut_s2 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a2_in_ready), .in_data(in_data),
      .out_valid(a2_out_valid), .out_ready(out_ready), .out_data(a2_out_data)
`ifdef C17_BIST_EN
      , .bist_start(bist_start), .bist_busy(a2_busy), .bist_done(a2_done), .bist_pass(a2_pass)
`endif
   );

   int n_chk  = 0;
   int n_fail = 0;
   int n_out  = 0;
   logic [2*CH-1:0] q[$];

   task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Sum-of-products form of c17: N22 = N1N3 + N2N11, N23 = N11(N2+N7), N11 = ~(N3N6).
   function automatic logic [1:0] c17_ref(input logic [4:0] v);
      logic n1, n2, n3, n6, n7, n11;
      {n7, n6, n3, n2, n1} = v;
      n11 = ~(n3 & n6);
      return {n11 & (n2 | n7), (n1 & n3) | (n2 & n11)};
   endfunction

   function automatic logic [2*CH-1:0] ref_word(input logic [5*CH-1:0] d);
      logic [2*CH-1:0] r;
      for (int c = 0; c < CH; c++) r[2*c +: 2] = c17_ref(d[5*c +: 5]);
      return r;
   endfunction

   function automatic logic [5*CH-1:0] rand_vec();
      logic [5*CH-1:0] r;
      for (int c = 0; c < CH; c++) r[5*c +: 5] = 5'($urandom_range(0, 31));
      return r;
   endfunction

   task automatic step();
      @(negedge clk);
      if (!rst) begin
         if (out_valid && out_ready) begin
            n_out++;
            if (q.size() == 0) chk_eq("sb_spurious", 32'd1, 32'd0);
            else               chk_eq("sb_data", 32'(out_data), 32'(q.pop_front()));
         end
         if (in_valid && in_ready) q.push_back(ref_word(in_data));
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drain(input string tag);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 20 && q.size() != 0; i++) step();
      chk_eq(tag, 32'(q.size()), 32'd0);
      repeat (S) step();
   endtask

   task automatic lat_test(input string tag, input logic [4:0] v);
      int l0, l1, l2;
      logic [2*CH-1:0] exp;
      l0 = 0; l1 = 0; l2 = 0;
      exp = ref_word({CH{v}});
      in_data   = {CH{v}};
      in_valid  = 1'b1;
      out_ready = 1'b1;
      chk_eq({tag, "_in_ready"}, 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      for (int t = 1; t <= 6; t++) begin
         if (out_valid && l0 == 0) begin
            l0 = t;
            chk_eq({tag, "_data_s3"}, 32'(out_data), 32'(exp));
         end
         if (a1_out_valid && l1 == 0) begin
            l1 = t;
            chk_eq({tag, "_data_s1"}, 32'(a1_out_data), 32'(exp));
         end
         if (a2_out_valid && l2 == 0) begin
            l2 = t;
            chk_eq({tag, "_data_s2"}, 32'(a2_out_data), 32'(exp));
         end
         @(posedge clk);
         #1;
      end
      chk_eq({tag, "_lat_s3"}, 32'(l0), 32'd3);
      chk_eq({tag, "_lat_s1"}, 32'(l1), 32'd1);
      chk_eq({tag, "_lat_s2"}, 32'(l2), 32'd2);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int base, bad, seen;
      logic have;
      logic [2*CH-1:0] held;
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; in_data = '0;
`ifdef C17_BIST_EN
      bist_start = 1'b0;
`endif
      repeat (3) @(posedge clk);
      #1;
      chk_eq("rst_out_valid", 32'(out_valid), 32'd0);
      chk_eq("rst_out_data", 32'(out_data), 32'd0);
      rst = 1'b0;
      #1;
      chk_eq("rst_in_ready", 32'(in_ready), 32'd1);

      lat_test("lat_00101", 5'b00101);

      // Exhaustive stream: channel c sees (i+c) mod 32.
      base = n_out;
      for (int i = 0; i < 32; i++) begin
         in_valid = 1'b1;
         for (int c = 0; c < CH; c++) in_data[5*c +: 5] = 5'(i + c);
         step();
      end
      drain("exh_drain");
      chk_eq("exh_count", 32'(n_out - base), 32'd32);

      // Backpressure: hold the sink off for 10 cycles.
      out_ready = 1'b0;
      bad = 0; have = 1'b0; held = '0;
      for (int i = 0; i < 10; i++) begin
         in_valid = 1'b1;
         in_data  = rand_vec();
         step();
         if (out_valid) begin
            if (have && out_data !== held) bad++;
            held = out_data;
            have = 1'b1;
         end
      end
      chk_eq("bp_accepts", 32'(q.size()), 32'd3);
      chk_eq("bp_in_ready", 32'(in_ready), 32'd0);
      chk_eq("bp_out_valid", 32'(out_valid), 32'd1);
      chk_eq("bp_stable", 32'(bad), 32'd0);
      base = n_out;
      drain("bp_drain");
      chk_eq("bp_released", 32'(n_out - base), 32'd3);

      // Random bubbles on both sides.
      for (int i = 0; i < 1000; i++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         in_data   = rand_vec();
         step();
      end
      drain("rnd_drain");

      // Reset with vectors in flight.
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1;
         in_data  = rand_vec();
         step();
      end
      #2;
      rst = 1'b1;
      in_valid = 1'b0;
      #1;
      chk_eq("mid_rst_out_valid", 32'(out_valid), 32'd0);
      chk_eq("mid_rst_out_data", 32'(out_data), 32'd0);
      q.delete();
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      chk_eq("mid_rst_in_ready", 32'(in_ready), 32'd1);
      seen = 0;
      for (int i = 0; i < 5; i++) begin
         if (out_valid || a1_out_valid || a2_out_valid) seen++;
         @(posedge clk);
         #1;
      end
      chk_eq("mid_rst_stale", 32'(seen), 32'd0);
      lat_test("rst_next_00011", 5'b00011);

`ifdef C17_BIST_EN
      bist_start = 1'b1;
      @(posedge clk);
      #1;
      bist_start = 1'b0;
      chk_eq("bist_in_ready", 32'(in_ready), 32'd0);
      seen = 0;
      while (bist_busy && seen < 100) begin
         seen++;
         @(posedge clk);
         #1;
      end
      chk_eq("bist_busy_cycles", 32'(seen), 32'(32 + S));
      chk_eq("bist_done", 32'(bist_done), 32'd1);
      chk_eq("bist_pass", 32'(bist_pass), 32'd1);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
